// File: rtl/arf054b256e1r1w0cbbeheaa4acw_rd_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : arf054b256e1r1w0cbbeheaa4acw_rd_pkg
// Brief    : Shared types and constants for the 256x54 1R1W array read path.
// Revision : 1.0
// ============================================================================
package arf054b256e1r1w0cbbeheaa4acw_rd_pkg;

   localparam int DWIDTH = 54;
   localparam int AWIDTH = 8;
   localparam int DEPTH  = 256;
   localparam int RD_LAT = 1;

   typedef logic [AWIDTH-1:0] addr_t;
   typedef logic [DWIDTH-1:0] data_t;

   typedef struct packed {
      logic  vld;
      logic  err;
      addr_t addr;
      logic  byp_vld;
      data_t byp_data;
   } rd_pipe_t;

   function automatic logic addr_legal(input addr_t addr, input int unsigned depth);
      return 32'(addr) < depth;
   endfunction

endpackage
`default_nettype wire

// File: rtl/arf054b256e1r1w0cbbeheaa4acw_rd_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : arf054b256e1r1w0cbbeheaa4acw_rd_ctrl_if
// Brief    : Request, array, write-snoop and response signals of the read path.
// Revision : 1.0
// ============================================================================
interface arf054b256e1r1w0cbbeheaa4acw_rd_ctrl_if
   import arf054b256e1r1w0cbbeheaa4acw_rd_pkg::*;
#(
   parameter int DWIDTH = arf054b256e1r1w0cbbeheaa4acw_rd_pkg::DWIDTH,
   parameter int AWIDTH = arf054b256e1r1w0cbbeheaa4acw_rd_pkg::AWIDTH
);
   logic              rd_req_vld;
   logic [AWIDTH-1:0] rd_req_addr;
   logic              rd_req_rdy;
   logic              arr_rd_en;
   logic [AWIDTH-1:0] arr_rd_addr;
   logic [DWIDTH-1:0] arr_rd_data;
   logic              wr_en;
   logic [AWIDTH-1:0] wr_addr;
   logic [DWIDTH-1:0] wr_data;
   logic              rd_rsp_vld;
   logic [DWIDTH-1:0] rd_rsp_data;
   logic              rd_rsp_err;
   logic              rd_rsp_rdy;

   modport master (
      output rd_req_vld, rd_req_addr, arr_rd_data, wr_en, wr_addr, wr_data, rd_rsp_rdy,
      input  rd_req_rdy, arr_rd_en, arr_rd_addr, rd_rsp_vld, rd_rsp_data, rd_rsp_err
   );

   modport slave (
      input  rd_req_vld, rd_req_addr, arr_rd_data, wr_en, wr_addr, wr_data, rd_rsp_rdy,
      output rd_req_rdy, arr_rd_en, arr_rd_addr, rd_rsp_vld, rd_rsp_data, rd_rsp_err
   );
endinterface
`default_nettype wire

// File: rtl/arf054b256e1r1w0cbbeheaa4acw_rd_rsp_fifo.sv
`default_nettype none
// ============================================================================
// Module   : arf054b256e1r1w0cbbeheaa4acw_rd_rsp_fifo
// Brief    : First-word-fall-through response FIFO; head is visible while !empty.
// Revision : 1.0
// ============================================================================
module arf054b256e1r1w0cbbeheaa4acw_rd_rsp_fifo #(
   parameter  int WIDTH = 55,
   parameter  int DEPTH = 4,
   localparam int CNT_W = $clog2(DEPTH + 1),
   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  wire              clk,
   input  wire              rst_b,
   input  wire              i_push,
   input  wire [WIDTH-1:0]  i_push_data,
   input  wire              i_pop,
   output logic [WIDTH-1:0] o_head,
   output logic             o_full,
   output logic             o_empty,
   output logic [CNT_W-1:0] o_count
);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [PTR_W-1:0] r_wptr;
   logic [PTR_W-1:0] r_rptr;
   logic [CNT_W-1:0] r_count;
   logic             w_do_pop;

   // Explicit wrap so non-power-of-two depths work.
   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   assign w_do_pop = i_pop && !o_empty;

   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
         for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      end else begin
         if (i_push) begin
            r_mem[r_wptr] <= i_push_data;
            r_wptr        <= ptr_inc(r_wptr);
         end
         if (w_do_pop) r_rptr <= ptr_inc(r_rptr);
         r_count <= r_count + CNT_W'(i_push) - CNT_W'(w_do_pop);
      end
   end

   assign o_head  = r_mem[r_rptr];
   assign o_empty = (r_count == '0);
   assign o_full  = (r_count == CNT_W'(DEPTH));
   assign o_count = r_count;

endmodule
`default_nettype wire

// File: rtl/arf054b256e1r1w0cbbeheaa4acw_rd_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : arf054b256e1r1w0cbbeheaa4acw_rd_ctrl
// Brief    : Credit-protected read controller with write-to-read bypass.
// Revision : 1.0
// ============================================================================
module arf054b256e1r1w0cbbeheaa4acw_rd_ctrl
   import arf054b256e1r1w0cbbeheaa4acw_rd_pkg::*;
#(
   parameter int DWIDTH    = arf054b256e1r1w0cbbeheaa4acw_rd_pkg::DWIDTH,
   parameter int AWIDTH    = arf054b256e1r1w0cbbeheaa4acw_rd_pkg::AWIDTH,
   parameter int DEPTH     = arf054b256e1r1w0cbbeheaa4acw_rd_pkg::DEPTH,
   parameter int RD_LAT    = arf054b256e1r1w0cbbeheaa4acw_rd_pkg::RD_LAT,
   parameter int RSP_DEPTH = 4
) (
   input wire clk,
   input wire rst_b,
   arf054b256e1r1w0cbbeheaa4acw_rd_ctrl_if.slave bus
);

   localparam int c_cnt_w = $clog2(RSP_DEPTH + 1);
   typedef logic [c_cnt_w-1:0] cnt_t;

   rd_pipe_t          r_pipe [RD_LAT];
   rd_pipe_t          w_upd  [RD_LAT];
   rd_pipe_t          w_new;
   rd_pipe_t          w_last;
   logic              r_run;
   cnt_t              w_count;
   cnt_t              w_inflight;
   cnt_t              w_credits;
   logic [AWIDTH-1:0] w_req_addr;
   logic              w_req_legal;
   logic              w_wr_legal;
   logic              w_accept;
   logic              w_push;
   logic              w_pop;
   logic              w_fifo_full;
   logic              w_fifo_empty;
   logic [DWIDTH:0]   w_push_word;
   logic [DWIDTH:0]   w_head_word;

   assign w_req_addr  = bus.rd_req_addr;
   assign w_req_legal = addr_legal(w_req_addr, DEPTH);
   assign w_wr_legal  = bus.wr_en && addr_legal(bus.wr_addr, DEPTH);

   always_comb begin
      w_inflight = '0;
      for (int i = 0; i < RD_LAT; i++) w_inflight = w_inflight + cnt_t'(r_pipe[i].vld);
   end

   // r_run holds ready low until the first edge after reset release.
   assign w_credits       = cnt_t'(RSP_DEPTH) - w_count - w_inflight;
   assign bus.rd_req_rdy  = r_run && (w_credits != '0);
   assign w_accept        = bus.rd_req_vld && bus.rd_req_rdy;
   assign bus.arr_rd_en   = w_accept && w_req_legal;
   assign bus.arr_rd_addr = bus.arr_rd_en ? w_req_addr : '0;

   always_comb begin
      w_new = '0;
      if (w_accept) begin
         w_new.vld  = 1'b1;
         w_new.err  = !w_req_legal;
         w_new.addr = w_req_addr;
         if (w_req_legal && w_wr_legal && (bus.wr_addr == w_req_addr)) begin
            w_new.byp_vld  = 1'b1;
            w_new.byp_data = bus.wr_data;
         end
      end
   end

   // Every in-flight stage snoops the write port; the youngest write wins.
   always_comb begin
      for (int i = 0; i < RD_LAT; i++) begin
         w_upd[i] = r_pipe[i];
         if (r_pipe[i].vld && !r_pipe[i].err && w_wr_legal && (bus.wr_addr == r_pipe[i].addr)) begin
            w_upd[i].byp_vld  = 1'b1;
            w_upd[i].byp_data = bus.wr_data;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         r_run <= 1'b0;
         for (int i = 0; i < RD_LAT; i++) r_pipe[i] <= '0;
      end else begin
         r_run     <= 1'b1;
         r_pipe[0] <= w_new;
         for (int i = 1; i < RD_LAT; i++) r_pipe[i] <= w_upd[i-1];
      end
   end

   assign w_last = w_upd[RD_LAT-1];
   assign w_push = w_last.vld;

   always_comb begin
      w_push_word = '0;
      if (w_last.err)          w_push_word = {1'b1, {DWIDTH{1'b0}}};
      else if (w_last.byp_vld) w_push_word = {1'b0, w_last.byp_data};
      else                     w_push_word = {1'b0, bus.arr_rd_data};
   end

   assign w_pop = !w_fifo_empty && bus.rd_rsp_rdy;

   arf054b256e1r1w0cbbeheaa4acw_rd_rsp_fifo #(
      .WIDTH (DWIDTH + 1),
      .DEPTH (RSP_DEPTH)
   ) u_rsp_fifo (
      .clk         (clk),
      .rst_b       (rst_b),
      .i_push      (w_push),
      .i_push_data (w_push_word),
      .i_pop       (w_pop),
      .o_head      (w_head_word),
      .o_full      (w_fifo_full),
      .o_empty     (w_fifo_empty),
      .o_count     (w_count)
   );

   assign bus.rd_rsp_vld                   = !w_fifo_empty;
   assign {bus.rd_rsp_err, bus.rd_rsp_data} = w_head_word;

   a_no_overflow: assert property (@(posedge clk) disable iff (!rst_b)
      !(w_push && w_fifo_full && !w_pop));

endmodule
`default_nettype wire

// File: tb/tb_arf054b256e1r1w0cbbeheaa4acw_rd_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_arf054b256e1r1w0cbbeheaa4acw_rd_ctrl
// Brief    : Directed bench; dut_a uses DEPTH=200/RD_LAT=1, dut_b RD_LAT=2.
// Revision : 1.0
// ============================================================================
module tb_arf054b256e1r1w0cbbeheaa4acw_rd_ctrl;

   localparam int DW = 54;
   localparam int AW = 8;

   logic clk   = 1'b0;
   logic rst_b = 1'b0;
   int   n_tests = 0;
   int   n_fail  = 0;

   always #5 clk = ~clk;

   arf054b256e1r1w0cbbeheaa4acw_rd_ctrl_if #(.DWIDTH(DW), .AWIDTH(AW)) ifa ();
   arf054b256e1r1w0cbbeheaa4acw_rd_ctrl_if #(.DWIDTH(DW), .AWIDTH(AW)) ifb ();

   arf054b256e1r1w0cbbeheaa4acw_rd_ctrl #(
      .DWIDTH(DW), .AWIDTH(AW), .DEPTH(200), .RD_LAT(1), .RSP_DEPTH(4)
   ) dut_a (.clk(clk), .rst_b(rst_b), .bus(ifa));

   arf054b256e1r1w0cbbeheaa4acw_rd_ctrl #(
      .DWIDTH(DW), .AWIDTH(AW), .DEPTH(256), .RD_LAT(2), .RSP_DEPTH(4)
   ) dut_b (.clk(clk), .rst_b(rst_b), .bus(ifb));

   // Array models: read returns pre-write contents; DUT outputs are sampled just before the edge.
   logic [DW-1:0] mem_a [256];
   logic [DW-1:0] mem_b [256];
   logic [DW-1:0] b_d1;
   logic          a_en_s = 1'b0, b_en_s = 1'b0;
   logic [AW-1:0] a_addr_s = '0, b_addr_s = '0;
   int            out_a = 0, out_b = 0;
   logic          ovf = 1'b0;

   always @(negedge clk) begin
      #3;
      a_en_s   = ifa.arr_rd_en;
      a_addr_s = ifa.arr_rd_addr;
      b_en_s   = ifb.arr_rd_en;
      b_addr_s = ifb.arr_rd_addr;
      if (!rst_b) begin
         out_a = 0;
         out_b = 0;
      end else begin
         out_a = out_a + int'(ifa.rd_req_vld && ifa.rd_req_rdy) - int'(ifa.rd_rsp_vld && ifa.rd_rsp_rdy);
         out_b = out_b + int'(ifb.rd_req_vld && ifb.rd_req_rdy) - int'(ifb.rd_rsp_vld && ifb.rd_rsp_rdy);
         if (out_a > 4 || out_b > 4 || out_a < 0 || out_b < 0) ovf = 1'b1;
      end
   end

   always @(posedge clk) begin
      ifa.arr_rd_data <= a_en_s ? mem_a[a_addr_s] : {DW{1'b1}};
      if (ifa.wr_en) mem_a[ifa.wr_addr] <= ifa.wr_data;
      b_d1            <= b_en_s ? mem_b[b_addr_s] : {DW{1'b1}};
      ifb.arr_rd_data <= b_d1;
      if (ifb.wr_en) mem_b[ifb.wr_addr] <= ifb.wr_data;
   end

   task automatic test_reset();
      #1;
      n_tests++; if (ifa.rd_req_rdy !== 1'b0) begin n_fail++; $display("FAIL reset_rdy: got %b want 0", ifa.rd_req_rdy); end
      n_tests++; if (ifa.arr_rd_en !== 1'b0) begin n_fail++; $display("FAIL reset_arr_en: got %b want 0", ifa.arr_rd_en); end
      n_tests++; if (ifa.arr_rd_addr !== 8'h00) begin n_fail++; $display("FAIL reset_arr_addr: got %h want 00", ifa.arr_rd_addr); end
      n_tests++; if (ifa.rd_rsp_vld !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_vld: got %b want 0", ifa.rd_rsp_vld); end
      n_tests++; if (ifa.rd_rsp_data !== 54'h0) begin n_fail++; $display("FAIL reset_rsp_data: got %h want 0", ifa.rd_rsp_data); end
      n_tests++; if (ifa.rd_rsp_err !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_err: got %b want 0", ifa.rd_rsp_err); end
      @(negedge clk);
      @(negedge clk);
      rst_b = 1'b1;
      @(posedge clk);
      #1;
      n_tests++; if (ifa.rd_req_rdy !== 1'b1) begin n_fail++; $display("FAIL reset_release_rdy_a: got %b want 1", ifa.rd_req_rdy); end
      n_tests++; if (ifb.rd_req_rdy !== 1'b1) begin n_fail++; $display("FAIL reset_release_rdy_b: got %b want 1", ifb.rd_req_rdy); end
   endtask

   task automatic test_single_read();
      @(negedge clk); ifa.rd_req_vld = 1'b1; ifa.rd_req_addr = 8'd5; #1;
      n_tests++; if (ifa.arr_rd_en !== 1'b1) begin n_fail++; $display("FAIL single_arr_en: got %b want 1", ifa.arr_rd_en); end
      n_tests++; if (ifa.arr_rd_addr !== 8'd5) begin n_fail++; $display("FAIL single_arr_addr: got %0d want 5", ifa.arr_rd_addr); end
      @(negedge clk); ifa.rd_req_vld = 1'b0; #1;
      n_tests++; if (ifa.rd_rsp_vld !== 1'b0) begin n_fail++; $display("FAIL single_early_vld: got %b want 0", ifa.rd_rsp_vld); end
      @(negedge clk); #1;
      n_tests++; if (ifa.rd_rsp_vld !== 1'b1) begin n_fail++; $display("FAIL single_vld: got %b want 1", ifa.rd_rsp_vld); end
      n_tests++; if (ifa.rd_rsp_data !== 54'h0AA) begin n_fail++; $display("FAIL single_data: got %h want 0aa", ifa.rd_rsp_data); end
      n_tests++; if (ifa.rd_rsp_err !== 1'b0) begin n_fail++; $display("FAIL single_err: got %b want 0", ifa.rd_rsp_err); end
      @(negedge clk); #1;
      n_tests++; if (ifa.rd_rsp_vld !== 1'b0) begin n_fail++; $display("FAIL single_drain: got %b want 0", ifa.rd_rsp_vld); end
   endtask

   task automatic test_back_to_back();
      int acc = 0;
      ifa.rd_rsp_rdy = 1'b0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk); ifa.rd_req_vld = 1'b1; ifa.rd_req_addr = 8'(acc); #1;
         n_tests++; if (ifa.rd_req_rdy !== (i < 4)) begin n_fail++; $display("FAIL b2b_rdy_cyc%0d: got %b want %b", i, ifa.rd_req_rdy, (i < 4)); end
         if (ifa.rd_req_rdy) acc++;
      end
      @(negedge clk); ifa.rd_req_vld = 1'b0;
      @(negedge clk); ifa.rd_rsp_rdy = 1'b1; #1;
      n_tests++; if (ifa.rd_req_rdy !== 1'b0) begin n_fail++; $display("FAIL b2b_rdy_full: got %b want 0", ifa.rd_req_rdy); end
      n_tests++; if (ifa.rd_rsp_data !== 54'h1000 || ifa.rd_rsp_vld !== 1'b1) begin n_fail++; $display("FAIL b2b_rsp0: got vld=%b data=%h want 1/1000", ifa.rd_rsp_vld, ifa.rd_rsp_data); end
      for (int k = 1; k < 4; k++) begin
         @(negedge clk); #1;
         n_tests++; if (ifa.rd_rsp_vld !== 1'b1 || ifa.rd_rsp_data !== DW'(32'h1000 + k)) begin n_fail++; $display("FAIL b2b_rsp%0d: got vld=%b data=%h want 1/%h", k, ifa.rd_rsp_vld, ifa.rd_rsp_data, 32'h1000 + k); end
         if (k == 1) begin
            n_tests++; if (ifa.rd_req_rdy !== 1'b1) begin n_fail++; $display("FAIL b2b_rdy_reassert: got %b want 1", ifa.rd_req_rdy); end
         end
      end
      @(negedge clk); #1;
      n_tests++; if (ifa.rd_rsp_vld !== 1'b0) begin n_fail++; $display("FAIL b2b_drain: got %b want 0", ifa.rd_rsp_vld); end
   endtask

   task automatic test_no_bypass();
      @(negedge clk); ifa.rd_req_vld = 1'b1; ifa.rd_req_addr = 8'd7;
      ifa.wr_en = 1'b1; ifa.wr_addr = 8'd8; ifa.wr_data = 54'h777;
      @(negedge clk); ifa.rd_req_vld = 1'b0; ifa.wr_en = 1'b0;
      @(negedge clk); #1;
      n_tests++; if (ifa.rd_rsp_vld !== 1'b1 || ifa.rd_rsp_data !== 54'h001) begin n_fail++; $display("FAIL no_bypass: got vld=%b data=%h want 1/001", ifa.rd_rsp_vld, ifa.rd_rsp_data); end
   endtask

   task automatic test_bypass_same();
      @(negedge clk); ifa.rd_req_vld = 1'b1; ifa.rd_req_addr = 8'd7;
      ifa.wr_en = 1'b1; ifa.wr_addr = 8'd7; ifa.wr_data = 54'h3FF;
      @(negedge clk); ifa.rd_req_vld = 1'b0; ifa.wr_en = 1'b0;
      @(negedge clk); #1;
      n_tests++; if (ifa.rd_rsp_vld !== 1'b1 || ifa.rd_rsp_data !== 54'h3FF) begin n_fail++; $display("FAIL bypass_same: got vld=%b data=%h want 1/3ff", ifa.rd_rsp_vld, ifa.rd_rsp_data); end
   endtask

   task automatic test_bypass_final();
      @(negedge clk); ifa.rd_req_vld = 1'b1; ifa.rd_req_addr = 8'd9;
      @(negedge clk); ifa.rd_req_vld = 1'b0;
      ifa.wr_en = 1'b1; ifa.wr_addr = 8'd9; ifa.wr_data = 54'h2AB;
      @(negedge clk); ifa.wr_en = 1'b0; #1;
      n_tests++; if (ifa.rd_rsp_vld !== 1'b1 || ifa.rd_rsp_data !== 54'h2AB) begin n_fail++; $display("FAIL bypass_final: got vld=%b data=%h want 1/2ab", ifa.rd_rsp_vld, ifa.rd_rsp_data); end
   endtask

   task automatic test_bypass_youngest();
      @(negedge clk); ifb.rd_req_vld = 1'b1; ifb.rd_req_addr = 8'd7;
      ifb.wr_en = 1'b1; ifb.wr_addr = 8'd7; ifb.wr_data = 54'h3FF;
      @(negedge clk); ifb.rd_req_vld = 1'b0; ifb.wr_data = 54'h155;
      @(negedge clk); ifb.wr_en = 1'b0; #1;
      n_tests++; if (ifb.rd_rsp_vld !== 1'b0) begin n_fail++; $display("FAIL youngest_early_vld: got %b want 0", ifb.rd_rsp_vld); end
      @(negedge clk); #1;
      n_tests++; if (ifb.rd_rsp_vld !== 1'b1 || ifb.rd_rsp_data !== 54'h155) begin n_fail++; $display("FAIL bypass_youngest: got vld=%b data=%h want 1/155", ifb.rd_rsp_vld, ifb.rd_rsp_data); end
      @(negedge clk); #1;
   endtask

   task automatic test_illegal();
      @(negedge clk); ifa.rd_req_vld = 1'b1; ifa.rd_req_addr = 8'd20; #1;
      n_tests++; if (ifa.arr_rd_en !== 1'b1) begin n_fail++; $display("FAIL illegal_prev_en: got %b want 1", ifa.arr_rd_en); end
      @(negedge clk); ifa.rd_req_addr = 8'd210;
      ifa.wr_en = 1'b1; ifa.wr_addr = 8'd210; ifa.wr_data = 54'h3FF; #1;
      n_tests++; if (ifa.arr_rd_en !== 1'b0 || ifa.rd_req_rdy !== 1'b1) begin n_fail++; $display("FAIL illegal_issue: got en=%b rdy=%b want 0/1", ifa.arr_rd_en, ifa.rd_req_rdy); end
      @(negedge clk); ifa.rd_req_addr = 8'd21; ifa.wr_en = 1'b0; #1;
      n_tests++; if (ifa.rd_rsp_vld !== 1'b1 || ifa.rd_rsp_data !== 54'h1014 || ifa.rd_rsp_err !== 1'b0) begin n_fail++; $display("FAIL illegal_rsp_before: got vld=%b data=%h err=%b want 1/1014/0", ifa.rd_rsp_vld, ifa.rd_rsp_data, ifa.rd_rsp_err); end
      @(negedge clk); ifa.rd_req_vld = 1'b0; #1;
      n_tests++; if (ifa.rd_rsp_vld !== 1'b1 || ifa.rd_rsp_data !== 54'h0 || ifa.rd_rsp_err !== 1'b1) begin n_fail++; $display("FAIL illegal_rsp: got vld=%b data=%h err=%b want 1/0/1", ifa.rd_rsp_vld, ifa.rd_rsp_data, ifa.rd_rsp_err); end
      @(negedge clk); #1;
      n_tests++; if (ifa.rd_rsp_vld !== 1'b1 || ifa.rd_rsp_data !== 54'h1015 || ifa.rd_rsp_err !== 1'b0) begin n_fail++; $display("FAIL illegal_rsp_after: got vld=%b data=%h err=%b want 1/1015/0", ifa.rd_rsp_vld, ifa.rd_rsp_data, ifa.rd_rsp_err); end
      @(negedge clk); #1;
   endtask

   task automatic test_reset_mid();
      int seen = 0;
      ifb.rd_rsp_rdy = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk); ifb.rd_req_vld = 1'b1; ifb.rd_req_addr = 8'(i); #1;
         n_tests++; if (ifb.rd_req_rdy !== 1'b1) begin n_fail++; $display("FAIL rstmid_rdy_cyc%0d: got %b want 1", i, ifb.rd_req_rdy); end
      end
      @(negedge clk); ifb.rd_req_vld = 1'b0; #1;
      n_tests++; if (ifb.rd_rsp_vld !== 1'b1) begin n_fail++; $display("FAIL rstmid_pre_vld: got %b want 1", ifb.rd_rsp_vld); end
      rst_b = 1'b0; #1;
      n_tests++; if (ifb.rd_rsp_vld !== 1'b0 || ifb.rd_req_rdy !== 1'b0) begin n_fail++; $display("FAIL rstmid_async: got vld=%b rdy=%b want 0/0", ifb.rd_rsp_vld, ifb.rd_req_rdy); end
      @(negedge clk);
      @(negedge clk); rst_b = 1'b1; ifb.rd_rsp_rdy = 1'b1;
      @(posedge clk); #1;
      n_tests++; if (ifb.rd_req_rdy !== 1'b1) begin n_fail++; $display("FAIL rstmid_rdy_release: got %b want 1", ifb.rd_req_rdy); end
      for (int i = 0; i < 6; i++) begin
         @(negedge clk); #1;
         if (ifb.rd_rsp_vld !== 1'b0) seen++;
      end
      n_tests++; if (seen != 0) begin n_fail++; $display("FAIL rstmid_stale_rsp: got %0d cycles with vld want 0", seen); end
   endtask

   initial begin
      for (int i = 0; i < 256; i++) begin
         mem_a[i] = DW'(32'h1000 + i);
         mem_b[i] = DW'(32'h2000 + i);
      end
      mem_a[5] = 54'h0AA;
      mem_a[7] = 54'h001;
      mem_b[7] = 54'h001;
      ifa.rd_req_vld = 1'b0; ifa.rd_req_addr = '0; ifa.wr_en = 1'b0; ifa.wr_addr = '0; ifa.wr_data = '0; ifa.rd_rsp_rdy = 1'b1;
      ifb.rd_req_vld = 1'b0; ifb.rd_req_addr = '0; ifb.wr_en = 1'b0; ifb.wr_addr = '0; ifb.wr_data = '0; ifb.rd_rsp_rdy = 1'b1;

      test_reset();
      test_single_read();
      test_back_to_back();
      test_no_bypass();
      test_bypass_same();
      test_bypass_final();
      test_bypass_youngest();
      test_illegal();
      test_reset_mid();

      n_tests++; if (ovf !== 1'b0) begin n_fail++; $display("FAIL credit_bound: outstanding out of range, got a=%0d b=%0d want <=4", out_a, out_b); end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
`default_nettype wire
